// File: rtl/pc_next_unit.sv
// Fetch-stage PC register and next-PC select for the pipelined 64-bit ARM core.
// Optional misaligned-target redirect to FAULT_VEC is enabled by defining PC_ALIGN_CHK_EN.
module pc_next_unit #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned INSTR_BYTES = 4,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [63:0] FAULT_VEC   = 64'h100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              id_uncond_br,
  input  logic [31:0]       id_instr,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              ex_br_taken,
  input  logic [31:0]       ex_instr,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_is_br,
  input  logic [ADDR_W-1:0] ex_br_addr,
  output logic [ADDR_W-1:0] pc_o,
  output logic              flush_if_o,
  output logic              flush_id_o,
  output logic              pend_o,
  output logic              fault_o
);

`ifdef PC_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] RESET_PC_W  = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] FAULT_VEC_W = FAULT_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] INCR_W      = ADDR_W'(INSTR_BYTES);

  logic [ADDR_W-1:0] pc_r, pend_tgt_r;
  logic              pend_r, fault_r;
  logic [ADDR_W-1:0] pc_d_s, pend_tgt_d_s;
  logic              pend_d_s, fault_d_s;

  logic [ADDR_W-1:0] off_id_s, off_cnd_s, t_id_s, t_cnd_s;
  logic [ADDR_W-1:0] tgt_s, apply_tgt_s;
  logic              redir_s, ex_redir_s, apply_s, misalign_s;
  logic              unused_s;

  assign off_id_s  = {{(ADDR_W-28){id_instr[25]}}, id_instr[25:0], 2'b00};
  assign off_cnd_s = {{(ADDR_W-21){ex_instr[23]}}, ex_instr[23:5], 2'b00};
  assign t_id_s    = id_pc + off_id_s;
  assign t_cnd_s   = ex_pc + off_cnd_s;
  assign unused_s  = ^{id_instr[31:26], ex_instr[31:24], ex_instr[4:0]};

  // Redirect arbitration: EX register branch, then EX conditional, then ID B/BL
  always_comb begin
    tgt_s      = '0;
    redir_s    = 1'b0;
    ex_redir_s = 1'b0;
    if (ex_is_br) begin
      tgt_s      = ex_br_addr;
      redir_s    = 1'b1;
      ex_redir_s = 1'b1;
    end else if (ex_br_taken) begin
      tgt_s      = t_cnd_s;
      redir_s    = 1'b1;
      ex_redir_s = 1'b1;
    end else if (id_uncond_br) begin
      tgt_s      = t_id_s;
      redir_s    = 1'b1;
    end else begin
      tgt_s      = '0;
      redir_s    = 1'b0;
    end
  end

  assign flush_if_o = redir_s;
  assign flush_id_o = ex_redir_s;

  // Next-state: stall capture/hold, live redirect over pending, else sequential
  always_comb begin
    pc_d_s       = pc_r;
    pend_d_s     = pend_r;
    pend_tgt_d_s = pend_tgt_r;
    apply_s      = 1'b0;
    apply_tgt_s  = '0;
    if (stall_i) begin
      if (redir_s && !pend_r) begin
        pend_d_s     = 1'b1;
        pend_tgt_d_s = tgt_s;
      end else begin
        pend_d_s     = pend_r;
      end
    end else if (redir_s) begin
      apply_s     = 1'b1;
      apply_tgt_s = tgt_s;
      pend_d_s    = 1'b0;
    end else if (pend_r) begin
      apply_s     = 1'b1;
      apply_tgt_s = pend_tgt_r;
      pend_d_s    = 1'b0;
    end else begin
      pc_d_s      = pc_r + INCR_W;
    end

    // Alignment is judged only when a target lands in the PC, never at capture
    misalign_s = ALIGN_CHK && apply_s && (apply_tgt_s[1:0] != 2'b00);
    fault_d_s  = misalign_s;
    if (misalign_s) begin
      pc_d_s = FAULT_VEC_W;
    end else if (apply_s) begin
      pc_d_s = apply_tgt_s;
    end else begin
      pc_d_s = pc_d_s;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r       <= RESET_PC_W;
      pend_r     <= 1'b0;
      pend_tgt_r <= '0;
      fault_r    <= 1'b0;
    end else begin
      pc_r       <= pc_d_s;
      pend_r     <= pend_d_s;
      pend_tgt_r <= pend_tgt_d_s;
      fault_r    <= fault_d_s;
    end
  end

  assign pc_o    = pc_r;
  assign pend_o  = pend_r;
  assign fault_o = fault_r;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed, table-driven bench for pc_next_unit; expectations follow the build's PC_ALIGN_CHK_EN setting.
module tb_pc_next_unit;

`ifdef PC_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, stall_i, id_uncond_br, ex_br_taken, ex_is_br;
  logic [31:0] id_instr, ex_instr;
  logic [63:0] id_pc, ex_pc, ex_br_addr, pc_o;
  logic        flush_if_o, flush_id_o, pend_o, fault_o;

  int n_cmp = 0;
  int n_bad = 0;

  pc_next_unit dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
    .id_uncond_br(id_uncond_br), .id_instr(id_instr), .id_pc(id_pc),
    .ex_br_taken(ex_br_taken), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_is_br(ex_is_br), .ex_br_addr(ex_br_addr),
    .pc_o(pc_o), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
    .pend_o(pend_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, ub, bt, isbr;
    logic [31:0] idi, exi;
    logic [63:0] idp, exp_pc_in, bra;
    logic [63:0] e_pc;
    logic        e_pend, e_fif, e_fid, e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic ub, input logic [31:0] idi, input logic [63:0] idp,
                              input logic bt, input logic [31:0] exi, input logic [63:0] exp_pc_in,
                              input logic isbr, input logic [63:0] bra, input logic [63:0] e_pc,
                              input logic e_pend, input logic e_fif, input logic e_fid, input logic e_fault);
    vec_t r;
    r.st = st; r.ub = ub; r.idi = idi; r.idp = idp; r.bt = bt; r.exi = exi; r.exp_pc_in = exp_pc_in;
    r.isbr = isbr; r.bra = bra; r.e_pc = e_pc; r.e_pend = e_pend; r.e_fif = e_fif; r.e_fid = e_fid;
    r.e_fault = e_fault;
    return r;
  endfunction

  function automatic vec_t idle(input logic [63:0] e_pc, input logic e_pend, input logic e_fault);
    return mk(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 64'h0, e_pc, e_pend, 1'b0, 1'b0, e_fault);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_i = v.st; id_uncond_br = v.ub; id_instr = v.idi; id_pc = v.idp;
    ex_br_taken = v.bt; ex_instr = v.exi; ex_pc = v.exp_pc_in; ex_is_br = v.isbr; ex_br_addr = v.bra;
  endtask

  task automatic check_outs(input int i, input vec_t v);
    check($sformatf("v%0d pc", i), pc_o, v.e_pc);
    check($sformatf("v%0d pend", i), {63'h0, pend_o}, {63'h0, v.e_pend});
    check($sformatf("v%0d flush_if", i), {63'h0, flush_if_o}, {63'h0, v.e_fif});
    check($sformatf("v%0d flush_id", i), {63'h0, flush_id_o}, {63'h0, v.e_fid});
    check($sformatf("v%0d fault", i), {63'h0, fault_o}, {63'h0, v.e_fault});
  endtask

  initial begin
    vec_t z;
    z = idle(64'h0, 1'b0, 1'b0);
    reset_n = 1'b0;
    drive(z);

    // Sequential fetch from reset
    vecs.push_back(idle(64'h0, 1'b0, 1'b0));
    vecs.push_back(idle(64'h4, 1'b0, 1'b0));
    vecs.push_back(idle(64'h8, 1'b0, 1'b0));
    vecs.push_back(idle(64'hC, 1'b0, 1'b0));
    // ID B/BL with negative imm26: 0x40 - 8 = 0x38
    vecs.push_back(mk(1'b0, 1'b1, 32'h03FF_FFFE, 64'h40, 1'b0, 32'h0, 64'h0, 1'b0, 64'h0,
                      64'h10, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(idle(64'h38, 1'b0, 1'b0));
    // All three redirect sources at once: BR wins
    vecs.push_back(mk(1'b0, 1'b1, 32'h03FF_FFFE, 64'h40, 1'b1, 32'h0000_0080, 64'h200, 1'b1, 64'h1000,
                      64'h3C, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(64'h1000, 1'b0, 1'b0));
    // Conditional, imm19=4 from 0x200 beats ID B/BL
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0010, 64'h40, 1'b1, 32'h0000_0080, 64'h200, 1'b0, 64'h0,
                      64'h1004, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(64'h210, 1'b0, 1'b0));
    // Conditional, imm19=-1 from 0x300 -> 0x2FC
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 32'h00FF_FFE0, 64'h300, 1'b0, 64'h0,
                      64'h214, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(64'h2FC, 1'b0, 1'b0));
    // Three stalled cycles: first redirect captured, later BR ignored, flushes don't follow pend
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 64'h0, 1'b1, 32'h0000_0080, 64'h200, 1'b0, 64'h0,
                      64'h300, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 64'h5000,
                      64'h300, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 64'h0,
                      64'h300, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(idle(64'h300, 1'b1, 1'b0));
    vecs.push_back(idle(64'h210, 1'b0, 1'b0));
    // Captured ID redirect (0x40+0x40) loses to live BR after release
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0010, 64'h40, 1'b0, 32'h0, 64'h0, 1'b0, 64'h0,
                      64'h214, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 64'h2000,
                      64'h214, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(64'h2000, 1'b0, 1'b0));
    // Misaligned live BR target
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 64'h1002,
                      64'h2004, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(CHK ? 64'h100 : 64'h1002, 1'b0, CHK));
    vecs.push_back(idle(CHK ? 64'h104 : 64'h1006, 1'b0, 1'b0));
    // Misaligned target captured while stalled, checked when applied
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 64'h3001,
                      CHK ? 64'h108 : 64'h100A, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(CHK ? 64'h108 : 64'h100A, 1'b1, 1'b0));
    vecs.push_back(idle(CHK ? 64'h100 : 64'h3001, 1'b0, CHK));
    // Wrap-around of the sequential increment
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
                      CHK ? 64'h104 : 64'h3005, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0));
    vecs.push_back(idle(64'h0, 1'b0, 1'b0));
    // Plain stall holds PC
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 64'h0,
                      64'h4, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(idle(64'h4, 1'b0, 1'b0));
    vecs.push_back(idle(64'h8, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    check("reset pc", pc_o, 64'h0);
    check("reset pend", {63'h0, pend_o}, 64'h0);
    check("reset fault", {63'h0, fault_o}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check_outs(i, vecs[i]);
      @(posedge clk);
      #2;
    end

    // Reset pulse while a redirect is pending
    drive(mk(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 64'h7000,
             64'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #2;
    check("mid-stall pend", {63'h0, pend_o}, 64'h1);
    check("mid-stall pc", pc_o, 64'hC);
    drive(mk(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 64'h0,
             64'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset_n = 1'b0;
    #1;
    check("async reset pc", pc_o, 64'h0);
    check("async reset pend", {63'h0, pend_o}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    stall_i = 1'b0;
    #1;
    check("post-reset pc0", pc_o, 64'h0);
    @(posedge clk);
    #2;
    check("post-reset pc1", pc_o, 64'h4);
    check("post-reset pend", {63'h0, pend_o}, 64'h0);
    @(posedge clk);
    #2;
    check("post-reset pc2", pc_o, 64'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
